countdown_timer_load: RTL and testbench

Loadable, prescaled down counter with a start/done/ack handshake: the count-down counterpart of the team's loadable up counter. It is loaded with a value, counts down to zero at a programmable tick rate, then flags completion and holds until acknowledged. It serves as the general-purpose timeout and interval source for control FSMs in the design.

---
 rtl/countdown_timer_load_pkg.sv | 13 +
 rtl/countdown_timer_load_tick_prescaler.sv | 34 +++
 rtl/countdown_timer_load.sv | 122 ++++++++++++
 tb/tb_countdown_timer_load.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_load_pkg.sv
// Shared types and defaults for the loadable, prescaled countdown timer.
package countdown_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_PRESCALE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/countdown_timer_load_tick_prescaler.sv
// Tick generator: fires once every prescale+1 enabled cycles; freezes on hold.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  hold,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    // >= rather than == so a prescale lowered below the running count ticks at once
    assign tick = !clear && !hold && (cnt >= prescale);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (cnt >= prescale) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer_load.sv
// Loadable prescaled down counter with start/done/ack handshake.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the load value on expiry instead of stopping.
module countdown_timer_load
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      data,
    input  logic                  start,
    input  logic                  pause,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  ack,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  tc_pulse
);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload, reload_n;
    logic             done_n;
    logic             tc_n;
    logic             tick;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clear    (load || (state != RUN)),
        .hold     (pause),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        done_n   = done;
        tc_n     = 1'b0;
        if (load) begin
            count_n  = data;
            reload_n = data;
            state_n  = IDLE;
            done_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state_n = RUN;
                        end else begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            tc_n    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (AUTO_RELOAD && ack) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count_n = count - WIDTH'(1);
                        end else begin
                            // expiry: reload skips the visible zero so the period is exactly reload ticks
                            tc_n = 1'b1;
                            if (AUTO_RELOAD && (reload != '0)) begin
                                count_n = reload;
                            end else begin
                                count_n = '0;
                                state_n = DONE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_n = IDLE;
                        done_n  = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            reload   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            reload   <= reload_n;
            busy     <= (state_n == RUN);
            done     <= done_n;
            tc_pulse <= tc_n;
        end
    end

endmodule

// File: tb/tb_countdown_timer_load.sv
// Scoreboard bench for countdown_timer_load; the reload scenario runs when COUNTDOWN_AUTO_RELOAD_EN is defined.
module tb_countdown_timer_load;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       start;
    logic       pause;
    logic [3:0] prescale;
    logic       ack;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       tc_pulse;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       tc;
    } exp_t;

    exp_t exp_q[$];

    countdown_timer_load dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data),
        .start    (start),
        .pause    (pause),
        .prescale (prescale),
        .ack      (ack),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .tc_pulse (tc_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, clock it, then pop and compare.
    task automatic cyc(input string tag, input int unsigned c, input bit b, input bit d, input bit t);
        exp_t e;
        exp_q.push_back('{tag, 8'(c), b, d, t});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".count"}, count, e.cnt);
        check({e.tag, ".busy"}, busy, e.busy);
        check({e.tag, ".done"}, done, e.done);
        check({e.tag, ".tc"}, tc_pulse, e.tc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned active;
        int unsigned c;

        rst = 1'b0; load = 1'b0; data = '0; start = 1'b0;
        pause = 1'b0; prescale = '0; ack = 1'b0;
        cyc("reset", 0, 0, 0, 0);
        rst = 1'b1;

        // start with count 0 goes straight to DONE with one pulse
        start = 1'b1;
        cyc("zero_start", 0, 0, 1, 1);
        start = 1'b0;
        cyc("zero_hold", 0, 0, 1, 0);
        ack = 1'b1;
        cyc("zero_ack", 0, 0, 0, 0);
        ack = 1'b0;

        // load beats a simultaneous start
        load = 1'b1; data = 8'd7; start = 1'b1;
        cyc("prio_load", 7, 0, 0, 0);
        load = 1'b0; start = 1'b0;
        cyc("prio_idle", 7, 0, 0, 0);

        // mid-run load returns to IDLE without a pulse
        load = 1'b1; data = 8'd6;
        cyc("mrl_load", 6, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("mrl_start", 6, 1, 0, 0);
        start = 1'b0;
        cyc("mrl_5", 5, 1, 0, 0);
        cyc("mrl_4", 4, 1, 0, 0);
        load = 1'b1; data = 8'd9;
        cyc("mrl_reload", 9, 0, 0, 0);
        load = 1'b0;
        cyc("mrl_idle", 9, 0, 0, 0);

        // reset mid-run with count 5
        load = 1'b1; data = 8'd5;
        cyc("rr_load", 5, 0, 0, 0);
        load = 1'b0; start = 1'b1; prescale = 4'd3;
        cyc("rr_start", 5, 1, 0, 0);
        start = 1'b0;
        cyc("rr_run", 5, 1, 0, 0);
        rst = 1'b0;
        cyc("rr_reset", 0, 0, 0, 0);
        rst = 1'b1;
        cyc("rr_after", 0, 0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // tick every 2 cycles, period of 2 ticks: 2,1 then back to 2 with a pulse
        load = 1'b1; data = 8'd2; prescale = 4'd1;
        cyc("ar_load", 2, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("ar_start", 2, 1, 0, 0);
        start = 1'b0;
        for (int unsigned p = 0; p < 3; p++) begin
            cyc("ar_a", 2, 1, 0, 0);
            cyc("ar_b", 1, 1, 0, 0);
            cyc("ar_c", 1, 1, 0, 0);
            cyc("ar_wrap", 2, 1, 0, 1);
        end
        ack = 1'b1;
        cyc("ar_ack", 2, 0, 0, 0);
        ack = 1'b0;
        cyc("ar_idle", 2, 0, 0, 0);
`else
        // one-shot at prescale 0
        load = 1'b1; data = 8'd3; prescale = 4'd0;
        cyc("os_load", 3, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("os_start", 3, 1, 0, 0);
        start = 1'b0;
        cyc("os_2", 2, 1, 0, 0);
        cyc("os_1", 1, 1, 0, 0);
        cyc("os_0", 0, 0, 1, 1);
        cyc("os_done", 0, 0, 1, 0);
        start = 1'b1;
        cyc("os_start_ign", 0, 0, 1, 0);
        start = 1'b0; ack = 1'b1;
        cyc("os_ack", 0, 0, 0, 0);
        ack = 1'b0;
        cyc("os_idle", 0, 0, 0, 0);

        // data 2, prescale 3, pause on edges 2 and 3 after start: done at edge 10
        load = 1'b1; data = 8'd2; prescale = 4'd3;
        cyc("pp_load", 2, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("pp_start", 2, 1, 0, 0);
        start = 1'b0;
        active = 0;
        for (int unsigned e = 1; e <= 10; e++) begin
            pause = (e == 2 || e == 3);
            if (!pause) active++;
            c = 2 - active / 4;
            if (e == 10) cyc("pp_done", 0, 0, 1, 1);
            else         cyc("pp_run", c, 1, 0, 0);
        end
        pause = 1'b0;
        cyc("pp_hold", 0, 0, 1, 0);
        ack = 1'b1;
        cyc("pp_ack", 0, 0, 0, 0);
        ack = 1'b0;
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
